inc_pipe: RTL
=============

Name: inc_pipe

Overview:
- Registered, handshaked version of the add-one chain: a → a+1 → a+2 → a+3 → a+4.
- Each stage is a clocked register that adds INC to the previous stage's value.
- The block consumes a stream of values and produces a stream with each value increased by STAGES*INC.
- Sits downstream of the stimulus source and feeds a scoreboard or waveform consumer.
- Provides valid/ready backpressure on both sides and reports occupancy.

Parameters:
- WIDTH, 3, data width; all arithmetic is modulo 2^WIDTH.
- STAGES, 4, number of register stages (≥1).
- INC, 1, constant added per stage; truncated to WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  input value.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  in_data + STAGES*INC, mod 2^WIDTH.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.
- busy  output  1  occupancy != 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All stage valid bits clear; all stage data registers = 0; occupancy = 0.
  - Outputs: out_valid=0, out_data=0, busy=0.
  - in_ready = 0 while rst is high.
  - Reset asserted mid-operation discards all in-flight items; no partial output is produced.
- Stage k (0..STAGES-1) holds v[k] and d[k]; when valid, d[k] = accepted input + (k+1)*INC.
- Stage ready:
  - rdy[STAGES] = out_ready.
  - rdy[k] = !v[k] | rdy[k+1].
  - in_ready = rdy[0] (combinational from out_ready; the registered ready path is not required).
- Stage k loads when rdy[k]:
  - v[k] <= v[k-1], with in_valid used for k=0.
  - d[k] <= d[k-1] + INC, with in_data + INC for k=0.
  - Data loads unconditionally whenever rdy[k]; data is don't-care when v=0, but the reset value is 0.
- Bubbles collapse: an empty stage accepts from upstream even if downstream is stalled.
- Latency: an item accepted in cycle N (in_valid & in_ready) has out_valid=1 in cycle N+STAGES when no stall occurs.
- Throughput: 1 item/cycle sustained with out_ready=1.
- Output mapping: out_valid = v[STAGES-1], out_data = d[STAGES-1].
- A stalled output holds out_data stable until out_ready.
- Occupancy:
  - +1 on in-fire alone, −1 on out-fire alone, unchanged when both fire in the same cycle.
  - Never exceeds STAGES.
  - When full and out_ready=0, in_ready=0.
- Wrap-around: with WIDTH=3, INC=1, STAGES=4, 6 → 2 and 7 → 3; no overflow flag.
- in_data is ignored when in_valid=0; no stage is marked valid.
- No X propagation: all registers are reset.

Optional Feature:
- Macro: INC_PIPE_TAP_EN.
- Defined:
  - Adds output tap_valid [STAGES] = {v[STAGES-1..0]}.
  - Adds output tap_data [STAGES*WIDTH], where slice k = d[k].
  - Both reset to 0. These expose the intermediate chain values b, c, d, e for waveform debug.
- Undefined:
  - The ports do not exist.
  - Behaviour is otherwise identical.

Decomposition:
- Package inc_pipe_pkg:
  - Default WIDTH/STAGES/INC localparams.
  - Function occ_width(stages) = $clog2(stages+1).
  - typedef stage_t {logic valid; logic [WIDTH-1:0] data}, using the default WIDTH.
- Sub-module inc_pipe_stage:
  - One register slice: valid/data in, downstream ready in.
  - Outputs: ready out, valid/data out.
  - Adds INC on load and uses synchronous reset.
- inc_pipe instantiates STAGES copies via generate and holds the occupancy counter.

Test Plan:
- Single item: after reset, in_data=0 with in_valid for 1 cycle, out_ready=1 → out_valid=1 exactly 4 cycles later with out_data=4; occupancy goes 1,1,1,1,0.
- Stream of 8 items: in_data=0..7 back-to-back, out_ready=1 → out_data=4,5,6,7,0,1,2,3 on consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0, offer 5 items (1,2,3,4,5) → 4 accepted, in_ready=0 on the 5th, occupancy=4. Then raise out_ready → outputs 5,6,7,0 in order, then item 5 → 1; no loss or duplication.
- Simultaneous events: pipeline full, out_ready=1 and in_valid=1 in the same cycle → one in-fire and one out-fire, occupancy stays 4.
- Reset mid-flight: 3 items in flight, assert rst for 1 cycle → next cycle out_valid=0, occupancy=0, out_data=0; a new item 2 yields out_data=6 four cycles after acceptance.
- Tap (INC_PIPE_TAP_EN defined): in_data=1 propagates → tap_data slices read 2, 3, 4, 5 as the item occupies stages 0–3; tap_valid walks 0001 → 0010 → 0100 → 1000.

Source files
------------

// File: rtl/inc_pipe_pkg.sv
// Shared defaults and helpers for the inc_pipe add-constant pipeline.
package inc_pipe_pkg;

  localparam int DEF_WIDTH  = 3;
  localparam int DEF_STAGES = 4;
  localparam int DEF_INC    = 1;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/inc_pipe_if.sv
// Valid/ready stream bundle for inc_pipe: upstream input side and downstream output side.
interface inc_pipe_if import inc_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/inc_pipe_stage.sv
// One register slice of the increment chain: loads upstream value + INC whenever it can
// accept, i.e. when empty or when its downstream is taking the current item.
module inc_pipe_stage import inc_pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INC   = DEF_INC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  assign ready = !valid || dn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      data  <= up_data + INC_W;
    end
  end

endmodule

// File: rtl/inc_pipe.sv
// Handshaked STAGES-deep pipeline adding INC per stage, with occupancy tracking.
// Optional INC_PIPE_TAP_EN exposes every stage's valid/data for waveform debug.
module inc_pipe import inc_pipe_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int INC    = DEF_INC
) (
  input  logic                          clk,
  input  logic                          rst,
  inc_pipe_if.slave                     bus,
  output logic [occ_width(STAGES)-1:0]  occupancy,
  output logic                          busy
`ifdef INC_PIPE_TAP_EN
  ,
  output logic [STAGES-1:0]             tap_valid,
  output logic [STAGES*WIDTH-1:0]       tap_data
`endif
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic              in_fire;
  logic              out_fire;

  // Each stage keeps its ready in its own scope so the ready chain is a plain
  // acyclic net per stage rather than a self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             dn_rdy;
    logic             rdy;

    if (k == 0) begin : g_src
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
    end else begin : g_mid
      assign up_valid = v[k-1];
      assign up_data  = d[k-1];
    end

    if (k == STAGES-1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_link
      assign dn_rdy = g_stage[k+1].rdy;
    end

    inc_pipe_stage #(
      .WIDTH (WIDTH),
      .INC   (INC)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (dn_rdy),
      .ready    (rdy),
      .valid    (v[k]),
      .data     (d[k])
    );

`ifdef INC_PIPE_TAP_EN
    assign tap_data[k*WIDTH +: WIDTH] = d[k];
`endif
  end

`ifdef INC_PIPE_TAP_EN
  assign tap_valid = v;
`endif

  assign bus.in_ready  = g_stage[0].rdy && !rst;
  assign bus.out_valid = v[STAGES-1];
  assign bus.out_data  = d[STAGES-1];

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else if (in_fire && !out_fire) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_fire && !in_fire) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

  assign busy = (occupancy != '0);

endmodule
